// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the write-back data cache.
package dcache_pkg;

   localparam int unsigned LINE_W      = 64;
   localparam int unsigned OFFSET_BITS = 2;

   typedef enum logic [1:0] {
      IDLE,
      WB,
      FILL,
      REFILL_DONE
   } state_e;

   function automatic int unsigned tag_bits(input int unsigned word_w,
                                            input int unsigned index_bits);
      return word_w - index_bits - OFFSET_BITS;
   endfunction

   function automatic int unsigned line_count(input int unsigned index_bits);
      return 32'd1 << index_bits;
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays for the direct-mapped cache; combinational read,
// word-write, whole-line fill and dirty-clear ports all addressed by one index.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int unsigned INDEX_BITS = 3,
   parameter int unsigned WORD_W     = 16,
   parameter int unsigned TAG_W      = tag_bits(16, 3)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [INDEX_BITS-1:0]  index,
   output logic                   rd_valid,
   output logic                   rd_dirty,
   output logic [TAG_W-1:0]       rd_tag,
   output logic [LINE_W-1:0]      rd_line,
   input  logic                   wr_en,
   input  logic [OFFSET_BITS-1:0] wr_offset,
   input  logic [WORD_W-1:0]      wr_data,
   input  logic                   fill_en,
   input  logic [TAG_W-1:0]       fill_tag,
   input  logic [LINE_W-1:0]      fill_line,
   input  logic                   clean_en
);

   localparam int unsigned LINES = line_count(INDEX_BITS);

   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  dirty_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINE_W-1:0] data_q [LINES];

   assign rd_valid = valid_q[index];
   assign rd_dirty = dirty_q[index];
   assign rd_tag   = tag_q[index];
   assign rd_line  = data_q[index];

   // Tag and data need no reset: valid gates every use of them.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
            tag_q[index]   <= fill_tag;
            data_q[index]  <= fill_line;
         end else if (wr_en) begin
            data_q[index][int'(wr_offset) * WORD_W +: WORD_W] <= wr_data;
            dirty_q[index] <= 1'b1;
         end
         if (clean_en) begin
            dirty_q[index] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller (FSM, address
// muxing). Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_wb_ctrl
   import dcache_pkg::*;
#(
   parameter int unsigned INDEX_BITS = 3,
   parameter int unsigned WORD_W     = 16,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         cpu_req,
   input  logic                         cpu_we,
   input  logic [WORD_W-1:0]            cpu_addr,
   input  logic [WORD_W-1:0]            cpu_wdata,
   output logic [WORD_W-1:0]            cpu_rdata,
   output logic                         cpu_ready,
   output logic                         mem_read,
   output logic                         mem_write_q,
   output logic [WORD_W-1:0]            mem_addr,
   output logic [LINE_WORDS*WORD_W-1:0] mem_wdata,
   input  logic [LINE_WORDS*WORD_W-1:0] mem_rdata,
   input  logic                         mem_ack,
   output logic [15:0]                  hit_count,
   output logic [15:0]                  miss_count
);

   localparam int unsigned TAG_W = tag_bits(WORD_W, INDEX_BITS);

   logic [TAG_W-1:0]       cpu_tag;
   logic [INDEX_BITS-1:0]  cpu_index;
   logic [OFFSET_BITS-1:0] cpu_offset;

   assign cpu_tag    = cpu_addr[WORD_W-1 -: TAG_W];
   assign cpu_index  = cpu_addr[INDEX_BITS+OFFSET_BITS-1 : OFFSET_BITS];
   assign cpu_offset = cpu_addr[OFFSET_BITS-1:0];

   logic              line_valid;
   logic              line_dirty;
   logic [TAG_W-1:0]  line_tag;
   logic [LINE_W-1:0] line_data;
   logic              hit;
   logic              word_we;
   logic              fill_en;
   logic              clean_en;

   assign hit = line_valid && (line_tag == cpu_tag);

   dcache_line_store #(
      .INDEX_BITS (INDEX_BITS),
      .WORD_W     (WORD_W),
      .TAG_W      (TAG_W)
   ) u_line_store (
      .clk       (clk),
      .reset_n   (reset_n),
      .index     (cpu_index),
      .rd_valid  (line_valid),
      .rd_dirty  (line_dirty),
      .rd_tag    (line_tag),
      .rd_line   (line_data),
      .wr_en     (word_we),
      .wr_offset (cpu_offset),
      .wr_data   (cpu_wdata),
      .fill_en   (fill_en),
      .fill_tag  (cpu_tag),
      .fill_line (mem_rdata),
      .clean_en  (clean_en)
   );

   state_e state_q, state_d;
   // High for the cycle after a write-back ack, keeping memory idle for one cycle.
   logic   gap_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= (state_q == WB) && mem_ack;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cpu_req && !hit) begin
               state_d = (line_valid && line_dirty) ? WB : FILL;
            end
         end
         WB: begin
            if (mem_ack) state_d = FILL;
         end
         FILL: begin
            if (mem_ack && !gap_q) state_d = REFILL_DONE;
         end
         REFILL_DONE: state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_comb begin
      cpu_ready   = 1'b0;
      cpu_rdata   = '0;
      mem_read    = 1'b0;
      mem_write_q = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      word_we     = 1'b0;
      fill_en     = 1'b0;
      clean_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req && hit) begin
               cpu_ready = 1'b1;
               if (cpu_we) begin
                  word_we = 1'b1;
               end else begin
                  cpu_rdata = line_data[int'(cpu_offset) * WORD_W +: WORD_W];
               end
            end
         end
         WB: begin
            mem_write_q = 1'b1;
            mem_addr    = {line_tag, cpu_index, {OFFSET_BITS{1'b0}}};
            mem_wdata   = line_data;
            clean_en    = mem_ack;
         end
         FILL: begin
            if (!gap_q) begin
               mem_read = 1'b1;
               mem_addr = {cpu_tag, cpu_index, {OFFSET_BITS{1'b0}}};
               fill_en  = mem_ack;
            end
         end
         default: ;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] hit_q;
   logic [15:0] miss_q;
   logic        count_hit;
   logic        count_miss;

   assign count_hit  = (state_q == IDLE) && cpu_req && hit;
   assign count_miss = (state_q == IDLE) && cpu_req && !hit;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (count_hit)  hit_q  <= hit_q + 16'd1;
         if (count_miss) miss_q <= miss_q + 16'd1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Directed bench for dcache_wb_ctrl against a quad-word memory that acks on the
// sixth cycle of each request; counter expectations follow DCACHE_STATS_EN.
module tb_dcache_wb_ctrl;

`ifdef DCACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int unsigned ACK_N = 6;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_read;
   logic        mem_write_q;
   logic [15:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ack;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   always #5 clk = ~clk;

   dcache_wb_ctrl u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ready   (cpu_ready),
      .mem_read    (mem_read),
      .mem_write_q (mem_write_q),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .hit_count   (hit_count),
      .miss_count  (miss_count)
   );

   // Memory model: word i preloads to 16'h5A00 | i.
   logic [15:0] mem [256];
   logic        mem_init = 1'b0;
   logic [7:0]  ra;
   int          ack_cnt;

   assign ra        = mem_addr[7:0];
   assign mem_rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
   assign mem_ack   = (mem_read || mem_write_q) && (ack_cnt == ACK_N - 1);

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h5A00 | 16'(i);
         mem_init <= 1'b1;
      end else if (mem_write_q && mem_ack) begin
         for (int k = 0; k < 4; k++) mem[ra + 8'(k)] <= mem_wdata[k*16 +: 16];
      end
      if (!reset_n) ack_cnt <= 0;
      else if ((mem_read || mem_write_q) && !mem_ack) ack_cnt <= ack_cnt + 1;
      else ack_cnt <= 0;
   end

   int total = 0;
   int bad   = 0;

   int          cyc;
   logic        done;
   logic        saw_read, saw_wq, overlap;
   logic [15:0] rd_addr, wq_addr, rdata;
   logic [63:0] wq_wdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      cyc = 0; done = 1'b0; saw_read = 1'b0; saw_wq = 1'b0; overlap = 1'b0;
      rd_addr = '0; wq_addr = '0; wq_wdata = '0; rdata = '0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (mem_read && mem_write_q) overlap = 1'b1;
         if (mem_read && !saw_read) begin saw_read = 1'b1; rd_addr = mem_addr; end
         if (mem_write_q && !saw_wq) begin
            saw_wq = 1'b1; wq_addr = mem_addr; wq_wdata = mem_wdata;
         end
         if (cpu_ready) begin
            done = 1'b1; rdata = cpu_rdata;
         end else begin
            @(posedge clk); #1; cyc++;
         end
      end
      check("ready_timeout", 64'(done), 64'd1);
   endtask

   task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wd);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      wait_ready();
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_we = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(cpu_ready), 64'd0);
      check("rst_read", 64'(mem_read), 64'd0);
      check("rst_wq", 64'(mem_write_q), 64'd0);
      check("rst_addr", 64'(mem_addr), 64'd0);
      check("rst_wdata", mem_wdata, 64'd0);
      check("rst_rdata", 64'(cpu_rdata), 64'd0);
      check("rst_hits", 64'(hit_count), 64'd0);
      check("rst_misses", 64'(miss_count), 64'd0);
      @(posedge clk); #1; reset_n = 1'b1;
      @(posedge clk); #1;

      access(1'b0, 16'h0023, 16'h0);
      check("cold_cycles", 64'(cyc), 64'd8);
      check("cold_read", 64'(saw_read), 64'd1);
      check("cold_raddr", 64'(rd_addr), 64'h20);
      check("cold_no_wq", 64'(saw_wq), 64'd0);
      check("cold_data", 64'(rdata), 64'h5A23);

      access(1'b0, 16'h0021, 16'h0);
      check("hit_cycles", 64'(cyc), 64'd0);
      check("hit_no_read", 64'(saw_read), 64'd0);
      check("hit_data", 64'(rdata), 64'h5A21);

      access(1'b1, 16'h0022, 16'hBEEF);
      check("st_cycles", 64'(cyc), 64'd0);
      check("st_no_mem", 64'(saw_read | saw_wq), 64'd0);

      access(1'b0, 16'h0042, 16'h0);
      check("dirty_cycles", 64'(cyc), 64'd15);
      check("dirty_wq", 64'(saw_wq), 64'd1);
      check("dirty_wq_addr", 64'(wq_addr), 64'h20);
      check("dirty_wq_w2", 64'(wq_wdata[47:32]), 64'hBEEF);
      check("dirty_wq_w0", 64'(wq_wdata[15:0]), 64'h5A20);
      check("dirty_raddr", 64'(rd_addr), 64'h40);
      check("dirty_overlap", 64'(overlap), 64'd0);
      check("dirty_data", 64'(rdata), 64'h5A42);

      @(negedge clk);
      check("stat_hits", 64'(hit_count), STATS ? 64'd4 : 64'd0);
      check("stat_misses", 64'(miss_count), STATS ? 64'd2 : 64'd0);

      // Reset in the middle of a clean fill of 0x0020's line.
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0022;
      repeat (3) begin @(negedge clk); @(posedge clk); #1; end
      @(negedge clk);
      check("fill_active", 64'(mem_read), 64'd1);
      check("fill_addr", 64'(mem_addr), 64'h20);
      @(posedge clk); #1;
      reset_n = 1'b0; cpu_req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_rst_read", 64'(mem_read), 64'd0);
      check("mid_rst_wq", 64'(mem_write_q), 64'd0);
      check("mid_rst_ready", 64'(cpu_ready), 64'd0);
      check("mid_rst_addr", 64'(mem_addr), 64'd0);
      check("mid_rst_hits", 64'(hit_count), 64'd0);
      check("mid_rst_misses", 64'(miss_count), 64'd0);
      @(posedge clk); #1; reset_n = 1'b1;
      @(posedge clk); #1;

      access(1'b0, 16'h0022, 16'h0);
      check("post_rst_cycles", 64'(cyc), 64'd8);
      check("post_rst_read", 64'(saw_read), 64'd1);
      check("post_rst_raddr", 64'(rd_addr), 64'h20);
      check("post_rst_data", 64'(rdata), 64'hBEEF);
      @(negedge clk);
      check("post_rst_hits", 64'(hit_count), STATS ? 64'd1 : 64'd0);
      check("post_rst_misses", 64'(miss_count), STATS ? 64'd1 : 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
